// File: rtl/apb_gpio_irq.sv
// APB GPIO block with per-pin output/enable registers, input synchronisers and a
// configurable edge/level interrupt controller with a registered irq.
// Optional feature: define GPIO_DEBOUNCE_EN to add a prescaled 4-tick input debouncer
// and its DBDIV register at offset 0x24. Without it, 0x24 is unmapped.

module apb_gpio_irq #(
  parameter int unsigned GPIO_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           paddr,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  // Word offsets (paddr[7:2])
  localparam logic [5:0] AddrOut   = 6'h00;
  localparam logic [5:0] AddrOe    = 6'h01;
  localparam logic [5:0] AddrIn    = 6'h02;
  localparam logic [5:0] AddrIen   = 6'h05;
  localparam logic [5:0] AddrItype = 6'h06;
  localparam logic [5:0] AddrIpol  = 6'h07;
  localparam logic [5:0] AddrIstat = 6'h08;
  localparam logic [5:0] AddrSet   = 6'h03;
  localparam logic [5:0] AddrClr   = 6'h04;
`ifdef GPIO_DEBOUNCE_EN
  localparam logic [5:0] AddrDbdiv = 6'h09;
`endif

  logic                  wr_en;
  logic                  rd_en;
  logic [5:0]            word;
  logic [GPIO_WIDTH-1:0] wdata;

  logic [GPIO_WIDTH-1:0] out_q;
  logic [GPIO_WIDTH-1:0] oe_q;
  logic [GPIO_WIDTH-1:0] ien_q;
  logic [GPIO_WIDTH-1:0] itype_q;
  logic [GPIO_WIDTH-1:0] ipol_q;
  logic [GPIO_WIDTH-1:0] istat_q;
  logic [GPIO_WIDTH-1:0] istat_d;
  logic                  irq_q;

  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;
  logic [GPIO_WIDTH-1:0] sync_last;
  logic [GPIO_WIDTH-1:0] filt;
  logic [GPIO_WIDTH-1:0] prev_q;

  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [GPIO_WIDTH-1:0] set_ev;
  logic [GPIO_WIDTH-1:0] istat_clr;

  // Address bits outside [7:2] and write bits above the pin count are don't-care.
  logic unused_bits;
  assign unused_bits = ^{paddr, pwdata};

  assign wr_en = psel & penable & pwrite;
  assign rd_en = psel & ~pwrite;
  assign word  = paddr[7:2];
  assign wdata = pwdata[GPIO_WIDTH-1:0];

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;
  assign irq      = irq_q;

  // Input synchroniser chain, stage 0 samples the pad
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [15:0]                 dbdiv_q;
  logic [15:0]                 presc_q;
  logic                        tick;
  logic [GPIO_WIDTH-1:0]       cand_q;
  logic [GPIO_WIDTH-1:0]       db_q;
  logic [GPIO_WIDTH-1:0][1:0]  dbcnt_q;

  // >= so that lowering DBDIV below the running count wraps at once
  assign tick = (presc_q >= dbdiv_q);

  // DBDIV register and tick prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbdiv_q <= '0;
      presc_q <= '0;
    end else begin
      presc_q <= tick ? 16'd0 : presc_q + 16'd1;
      if (wr_en && word == AddrDbdiv) begin
        dbdiv_q <= pwdata[15:0];
      end
    end
  end

  // Per-pin filter: cand tracks the sampled value, dbcnt counts repeats beyond the first;
  // the fourth equal tick in a row commits the value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q  <= '0;
      db_q    <= '0;
      dbcnt_q <= '0;
    end else if (tick) begin
      for (int i = 0; i < int'(GPIO_WIDTH); i++) begin
        if (sync_last[i] != cand_q[i]) begin
          cand_q[i]  <= sync_last[i];
          dbcnt_q[i] <= 2'd0;
        end else begin
          if (dbcnt_q[i] != 2'd3) begin
            dbcnt_q[i] <= dbcnt_q[i] + 2'd1;
          end
          if (dbcnt_q[i] >= 2'd2) begin
            db_q[i] <= cand_q[i];
          end
        end
      end
    end
  end

  assign filt = db_q;
`else
  assign filt = sync_last;
`endif

  // Previous filtered value for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= filt;
    end
  end

  // Interrupt event detection and ISTAT next state (a set beats a same-cycle clear)
  always_comb begin
    rise      = filt & ~prev_q;
    fall      = ~filt & prev_q;
    set_ev    = (itype_q & ((~ipol_q & rise) | (ipol_q & fall)))
              | (~itype_q & (filt ^ ipol_q));
    istat_clr = (wr_en && word == AddrIstat) ? wdata : '0;
    istat_d   = (istat_q & ~istat_clr) | set_ev;
  end

  // Software-visible control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      oe_q    <= '0;
      ien_q   <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
    end else if (wr_en) begin
      case (word)
        AddrOut:   out_q   <= wdata;
        AddrOe:    oe_q    <= wdata;
        AddrSet:   out_q   <= out_q | wdata;
        AddrClr:   out_q   <= out_q & ~wdata;
        AddrIen:   ien_q   <= wdata;
        AddrItype: itype_q <= wdata;
        AddrIpol:  ipol_q  <= wdata;
        default: ;
      endcase
    end
  end

  // Interrupt status and registered interrupt output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      istat_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      istat_q <= istat_d;
      irq_q   <= |(istat_q & ien_q);
    end
  end

  // Combinational read mux; SET/CLR and unmapped offsets read as zero
  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (word)
        AddrOut:   prdata[GPIO_WIDTH-1:0] = out_q;
        AddrOe:    prdata[GPIO_WIDTH-1:0] = oe_q;
        AddrIn:    prdata[GPIO_WIDTH-1:0] = filt;
        AddrIen:   prdata[GPIO_WIDTH-1:0] = ien_q;
        AddrItype: prdata[GPIO_WIDTH-1:0] = itype_q;
        AddrIpol:  prdata[GPIO_WIDTH-1:0] = ipol_q;
        AddrIstat: prdata[GPIO_WIDTH-1:0] = istat_q;
`ifdef GPIO_DEBOUNCE_EN
        AddrDbdiv: prdata[15:0]           = dbdiv_q;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Self-checking bench for apb_gpio_irq: a queue-based reference model checked every
// cycle, plus directed sequences with hand-computed literal expectations.
// Builds with or without GPIO_DEBOUNCE_EN.

module tb_apb_gpio_irq;
  localparam int W = 4;
  localparam int S = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int Lat = S + 4;  // four debounce ticks at DBDIV = 0
`else
  localparam int Lat = S;
`endif

  logic          clk;
  logic          reset;
  logic [15:0]   paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [31:0]   pwdata;
  logic [31:0]   prdata;
  logic [W-1:0]  gpio_in;
  logic [W-1:0]  gpio_out;
  logic [W-1:0]  gpio_oe;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  apb_gpio_irq #(.GPIO_WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk     (clk),
    .reset   (reset),
    .paddr   (paddr),
    .pwrite  (pwrite),
    .psel    (psel),
    .penable (penable),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe (gpio_oe),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_out, m_oe, m_ien, m_itype, m_ipol, m_istat, m_prev, m_db;
  logic         m_irq;
  logic [15:0]  m_dbdiv, m_pc;
  logic [W-1:0] hist[$];  // pad samples, newest first
  logic [W-1:0] tq[$];    // tick-sampled synchronised values, newest first
  logic [W-1:0] t_sync, t_filt, t_ev, t_clr;
  logic         t_tick;

  function automatic logic [W-1:0] hist_at(input int i);
    return (i < hist.size()) ? hist[i] : '0;
  endfunction

  function automatic logic [W-1:0] m_in();
`ifdef GPIO_DEBOUNCE_EN
    return m_db;
`else
    return hist_at(S - 1);
`endif
  endfunction

  function automatic logic [31:0] m_read(input logic [15:0] a);
    case (a[7:2])
      6'd0: return 32'(m_out);
      6'd1: return 32'(m_oe);
      6'd2: return 32'(m_in());
      6'd5: return 32'(m_ien);
      6'd6: return 32'(m_itype);
      6'd7: return 32'(m_ipol);
      6'd8: return 32'(m_istat);
`ifdef GPIO_DEBOUNCE_EN
      6'd9: return 32'(m_dbdiv);
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = '0; m_oe = '0; m_ien = '0; m_itype = '0; m_ipol = '0; m_istat = '0;
      m_prev = '0; m_db = '0; m_irq = 1'b0; m_dbdiv = '0; m_pc = '0;
      hist.delete();
      tq.delete();
    end else begin
      t_sync = hist_at(S - 1);
`ifdef GPIO_DEBOUNCE_EN
      t_filt = m_db;
`else
      t_filt = t_sync;
`endif
      for (int i = 0; i < W; i++) begin
        if (m_itype[i])
          t_ev[i] = m_ipol[i] ? (!t_filt[i] && m_prev[i]) : (t_filt[i] && !m_prev[i]);
        else
          t_ev[i] = (t_filt[i] != m_ipol[i]);
      end
      t_clr   = (psel && penable && pwrite && paddr[7:2] == 6'd8) ? pwdata[W-1:0] : '0;
      m_irq   = |(m_istat & m_ien);
      m_istat = (m_istat & ~t_clr) | t_ev;
      m_prev  = t_filt;
`ifdef GPIO_DEBOUNCE_EN
      t_tick = (m_pc >= m_dbdiv);
      m_pc   = t_tick ? 16'd0 : m_pc + 16'd1;
      if (t_tick) begin
        tq.push_front(t_sync);
        if (tq.size() > 4) void'(tq.pop_back());
        if (tq.size() == 4)
          for (int i = 0; i < W; i++)
            if (tq[0][i] == tq[1][i] && tq[1][i] == tq[2][i] && tq[2][i] == tq[3][i])
              m_db[i] = tq[0][i];
      end
`endif
      if (psel && penable && pwrite) begin
        case (paddr[7:2])
          6'd0: m_out   = pwdata[W-1:0];
          6'd1: m_oe    = pwdata[W-1:0];
          6'd3: m_out   = m_out | pwdata[W-1:0];
          6'd4: m_out   = m_out & ~pwdata[W-1:0];
          6'd5: m_ien   = pwdata[W-1:0];
          6'd6: m_itype = pwdata[W-1:0];
          6'd7: m_ipol  = pwdata[W-1:0];
`ifdef GPIO_DEBOUNCE_EN
          6'd9: m_dbdiv = pwdata[15:0];
`endif
          default: ;
        endcase
      end
      hist.push_front(gpio_in);
      if (hist.size() > S) void'(hist.pop_back());
    end
  end

  // Every-cycle comparison against the model, sampled after the edge settles
  always begin
    @(posedge clk);
    #1;
    check("cyc gpio_out", 32'(gpio_out), 32'(m_out));
    check("cyc gpio_oe", 32'(gpio_oe), 32'(m_oe));
    check("cyc irq", 32'(irq), 32'(m_irq));
    check("cyc prdata", prdata, (psel && !pwrite) ? m_read(paddr) : 32'd0);
  end

  // ---------------- APB helpers ----------------
  task automatic apb_wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [15:0] a, input logic [31:0] exp, input string name);
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    #1;
    check(name, prdata, exp);
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; gpio_in = '0;
    repeat (3) @(negedge clk);
    check("reset gpio_out", 32'(gpio_out), 32'h0);
    check("reset gpio_oe", 32'(gpio_oe), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    reset = 1'b0;

    // All offsets read zero after reset
    for (int a = 0; a <= 9; a++) apb_rd(16'(a * 4), 32'h0, "reset read");
    check("post-reset gpio_oe", 32'(gpio_oe), 32'h0);
    check("post-reset irq", 32'(irq), 32'h0);

    // OUT / SET / CLR
    apb_wr(16'h00, 32'h5);
    check("out write", 32'(gpio_out), 32'h5);
    apb_wr(16'h0C, 32'h2);
    check("set", 32'(gpio_out), 32'h7);
    apb_wr(16'h10, 32'h1);
    check("clr", 32'(gpio_out), 32'h6);
    apb_rd(16'h00, 32'h6, "out readback");
    apb_rd(16'h0C, 32'h0, "set reads zero");
    apb_rd(16'h10, 32'h0, "clr reads zero");
    apb_wr(16'h00, 32'hFFFF_FFFF);
    apb_rd(16'h00, 32'hF, "out width mask");
    apb_wr(16'h04, 32'hA);
    check("oe drive", 32'(gpio_oe), 32'hA);
    apb_rd(16'h04, 32'hA, "oe readback");
    apb_wr(16'h08, 32'hF);
    apb_rd(16'h08, 32'h0, "in not writable");
    apb_wr(16'h28, 32'hF);
    apb_rd(16'h28, 32'h0, "unmapped read");
`ifndef GPIO_DEBOUNCE_EN
    apb_wr(16'h24, 32'hF);
    apb_rd(16'h24, 32'h0, "0x24 unmapped");
`endif

    // Rising edge on pin 0
    apb_wr(16'h18, 32'h1);
    apb_wr(16'h1C, 32'h0);
    apb_wr(16'h14, 32'h1);
    apb_rd(16'h20, 32'h0, "istat idle");
    @(negedge clk);
    gpio_in = 4'h1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = 16'h20;
    for (int k = 1; k <= Lat + 3; k++) begin
      @(posedge clk);
      #1;
      check("edge istat timing", prdata, (k >= Lat + 1) ? 32'h1 : 32'h0);
      check("edge irq timing", 32'(irq), (k >= Lat + 2) ? 32'h1 : 32'h0);
    end
    apb_wr(16'h20, 32'h1);
    check("irq one cycle after w1c", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq cleared", 32'(irq), 32'h0);
    apb_rd(16'h20, 32'h0, "istat cleared");

    // Level-low on pin 2 (pin 0 is level-high and active, but not enabled)
    apb_wr(16'h18, 32'h0);
    apb_wr(16'h1C, 32'h4);
    apb_wr(16'h14, 32'h4);
    repeat (3) @(negedge clk);
    check("level irq", 32'(irq), 32'h1);
    apb_rd(16'h20, 32'h5, "level istat");
    apb_wr(16'h20, 32'h4);
    check("level irq after clr", 32'(irq), 32'h1);
    apb_rd(16'h20, 32'h5, "level re-set");
    repeat (2) @(negedge clk);
    check("level irq holds", 32'(irq), 32'h1);
    @(negedge clk);
    gpio_in = 4'h5;
    repeat (Lat + 2) @(negedge clk);
    apb_wr(16'h20, 32'h4);
    check("level irq drain", 32'(irq), 32'h1);
    @(negedge clk);
    check("level irq falls", 32'(irq), 32'h0);
    apb_rd(16'h20, 32'h1, "level istat after release");

    // Edge on pin 1 coincides with W1C of bit 1: set wins
    apb_wr(16'h1C, 32'h0);
    apb_wr(16'h18, 32'h2);
    @(negedge clk);
    gpio_in = 4'h7;
    repeat (Lat - 2) @(negedge clk);
    apb_wr(16'h20, 32'h2);
    apb_rd(16'h20, 32'h7, "set beats clear");

    // Reset during the access phase of a write
    @(negedge clk);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 16'h04; pwdata = 32'h5;
    @(negedge clk);
    penable = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    reset = 1'b0;
    check("abort gpio_out", 32'(gpio_out), 32'h0);
    check("abort gpio_oe", 32'(gpio_oe), 32'h0);
    apb_rd(16'h04, 32'h0, "abort oe");
    apb_rd(16'h14, 32'h0, "abort ien");
    repeat (Lat + 3) @(negedge clk);
    apb_rd(16'h20, 32'h7, "post-reset level istat");
    check("post-reset irq", 32'(irq), 32'h0);

`ifdef GPIO_DEBOUNCE_EN
    gpio_in = 4'h0;
    apb_wr(16'h18, 32'hF);
    repeat (Lat + 4) @(negedge clk);
    apb_wr(16'h20, 32'hF);
    apb_wr(16'h24, 32'h1_2345);
    apb_rd(16'h24, 32'h2345, "dbdiv width");
    apb_wr(16'h24, 32'h3);
    apb_rd(16'h24, 32'h3, "dbdiv readback");
    @(negedge clk);
    gpio_in = 4'h1;
    repeat (6) @(negedge clk);
    gpio_in = 4'h0;
    repeat (12) @(negedge clk);
    apb_rd(16'h08, 32'h0, "glitch filtered");
    apb_rd(16'h20, 32'h0, "glitch no istat");
    gpio_in = 4'h1;
    repeat (20) @(negedge clk);
    apb_rd(16'h08, 32'h1, "debounced high");
    apb_rd(16'h20, 32'h1, "debounced edge");
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
